// File: rtl/easy_fifo_pkg.sv
// Shared types and width helpers for the async FIFO write-side front end.
// Default geometry plus the packed layout of a wide FIFO word.
package easy_fifo_pkg;

    localparam int IN_WIDTH_DEF  = 64;
    localparam int RATIO_DEF     = 4;
    localparam int DEPTH_DEF     = 4;
    localparam int AF_MARGIN_DEF = 1;

    function automatic int aw_f(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int lw_f(input int ratio);
        return $clog2(ratio);
    endfunction

    localparam int AWIDTH = aw_f(DEPTH_DEF);
    localparam int LW     = lw_f(RATIO_DEF);

    typedef struct packed {
        logic                            last;
        logic [LW-1:0]                   cnt_m1;
        logic [IN_WIDTH_DEF*RATIO_DEF-1:0] lanes;
    } wr_word_t;

endpackage

// File: rtl/gray2bin.sv
// Gray-code to binary converter.
// Each binary bit is the XOR of all gray bits at or above it.
module gray2bin #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] gray,
    output logic [SIZE-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < SIZE; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/async_wr_packer.sv
// Packs RATIO narrow stream beats into one wide FIFO word and drives the
// write controller; also tracks write-side fill level and almost-full.
module async_wr_packer
    import easy_fifo_pkg::*;
#(
    parameter int IN_WIDTH  = IN_WIDTH_DEF,
    parameter int RATIO     = RATIO_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AF_MARGIN = AF_MARGIN_DEF
) (
    input  logic                                  wr_clk,
    input  logic                                  rst,
    input  logic                                  s_tvalid,
    output logic                                  s_tready,
    input  logic [IN_WIDTH-1:0]                   s_tdata,
    input  logic                                  s_tlast,
    output logic                                  wr_en,
    output logic [IN_WIDTH*RATIO+lw_f(RATIO):0]   wr_data,
    input  logic                                  wr_full,
    input  logic [aw_f(DEPTH):0]                  wr_ptr,
    input  logic [aw_f(DEPTH):0]                  rd_ptr_wsync,
    output logic [aw_f(DEPTH):0]                  wr_level,
    output logic                                  almost_full
);

    localparam int AW = aw_f(DEPTH);
    localparam int LWD = lw_f(RATIO);
    localparam int LANES_W = IN_WIDTH * RATIO;
    localparam int WORD_W = LANES_W + LWD + 1;
    localparam logic [AW:0] AF_TH = (AW+1)'(DEPTH - AF_MARGIN);
    localparam logic [LWD-1:0] LAST_LANE = LWD'(RATIO - 1);

    logic [LWD-1:0]     lane_cnt_q, lane_cnt_d;
    logic [LANES_W-1:0] lanes_q, lanes_d, lanes_ins;
    logic               pend_valid_q, pend_valid_d;
    logic [WORD_W-1:0]  pend_q, pend_d;
    logic [AW:0]        level_q, level_d;
    logic               af_q, af_d;
    logic [AW:0]        wr_bin, rd_bin;
    logic               accept, complete;

    gray2bin #(.SIZE(AW + 1)) u_wr_g2b (
        .gray (wr_ptr),
        .bin  (wr_bin)
    );

    gray2bin #(.SIZE(AW + 1)) u_rd_g2b (
        .gray (rd_ptr_wsync),
        .bin  (rd_bin)
    );

    assign s_tready = ~rst & (~pend_valid_q | ~wr_full);
    assign wr_en    = pend_valid_q & ~wr_full & ~rst;
    assign accept   = s_tvalid & s_tready;
    assign complete = accept & ((lane_cnt_q == LAST_LANE) | s_tlast);

    always_comb begin
        lanes_ins = lanes_q;
        for (int i = 0; i < RATIO; i++) begin
            if (lane_cnt_q == LWD'(i)) begin
                lanes_ins[i*IN_WIDTH +: IN_WIDTH] = s_tdata;
            end
        end
    end

    // A drain and a fresh completion in the same cycle reload without a bubble
    always_comb begin
        lane_cnt_d   = lane_cnt_q;
        lanes_d      = lanes_q;
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        if (wr_en) begin
            pend_valid_d = 1'b0;
        end
        if (complete) begin
            lane_cnt_d   = '0;
            lanes_d      = '0;
            pend_valid_d = 1'b1;
            pend_d       = {s_tlast, lane_cnt_q, lanes_ins};
        end else if (accept) begin
            lane_cnt_d = lane_cnt_q + 1'b1;
            lanes_d    = lanes_ins;
        end
    end

    always_comb begin
        level_d = wr_bin - rd_bin;
        af_d    = (level_d >= AF_TH);
    end

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            lane_cnt_q   <= '0;
            lanes_q      <= '0;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            level_q      <= '0;
            af_q         <= 1'b0;
        end else begin
            lane_cnt_q   <= lane_cnt_d;
            lanes_q      <= lanes_d;
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            level_q      <= level_d;
            af_q         <= af_d;
        end
    end

    assign wr_data     = pend_q;
    assign wr_level    = level_q;
    assign almost_full = af_q;

endmodule

// File: tb/tb_async_wr_packer.sv
// Scoreboard bench for async_wr_packer: a beat-level model predicts
// packed words, ready and write strobes; level path checked directly.
module tb_async_wr_packer;
    import easy_fifo_pkg::*;

    localparam int W  = 64;
    localparam int WW = W * 4 + 2 + 1;

    logic          wr_clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [W-1:0]  s_tdata = '0;
    logic          s_tlast = 1'b0;
    logic          wr_en;
    logic [WW-1:0] wr_data;
    logic          wr_full = 1'b0;
    logic [2:0]    wr_ptr = '0;
    logic [2:0]    rd_ptr_wsync = '0;
    logic [2:0]    wr_level;
    logic          almost_full;

    int n_chk = 0;
    int n_pass = 0;
    int n_wr = 0;

    logic          mon_en = 1'b0;
    logic          exp_rdy = 1'b0;
    logic          exp_wen = 1'b0;
    wr_word_t      sb[$];
    logic [255:0]  m_lanes = '0;
    int            m_cnt = 0;

    async_wr_packer dut (
        .wr_clk       (wr_clk),
        .rst          (rst),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .s_tdata      (s_tdata),
        .s_tlast      (s_tlast),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .wr_full      (wr_full),
        .wr_ptr       (wr_ptr),
        .rd_ptr_wsync (rd_ptr_wsync),
        .wr_level     (wr_level),
        .almost_full  (almost_full)
    );

    always #5 wr_clk = ~wr_clk;

    always @(negedge wr_clk) begin
        if (mon_en) begin
            wr_word_t got;
            wr_word_t exp;
            n_chk++;
            if (s_tready !== exp_rdy)
                $display("FAIL ready: got %b want %b", s_tready, exp_rdy);
            else
                n_pass++;
            n_chk++;
            if (wr_en !== exp_wen)
                $display("FAIL wr_en: got %b want %b", wr_en, exp_wen);
            else
                n_pass++;
            if (exp_wen) begin
                got = wr_word_t'(wr_data);
                exp = sb.pop_front();
                n_wr++;
                n_chk++;
                if (got !== exp)
                    $display("FAIL word: got last=%b cnt=%0d lanes=%h want last=%b cnt=%0d lanes=%h",
                             got.last, got.cnt_m1, got.lanes,
                             exp.last, exp.cnt_m1, exp.lanes);
                else
                    n_pass++;
            end
        end
    end

    function automatic logic [2:0] b2g(input logic [2:0] b);
        return b ^ (b >> 1);
    endfunction

    // One cycle of stimulus; the model decides acceptance from its own state
    task automatic drive_cycle(input logic v, input logic [W-1:0] d,
                               input logic l, input logic f,
                               output logic acc);
        logic pend;
        wr_word_t w;
        s_tvalid = v;
        s_tdata  = d;
        s_tlast  = l;
        wr_full  = f;
        pend     = (sb.size() != 0);
        exp_rdy  = ~pend | ~f;
        exp_wen  = pend & ~f;
        acc      = v & exp_rdy;
        if (acc) begin
            m_lanes[m_cnt*W +: W] = d;
            if (m_cnt == 3 || l) begin
                w.last   = l;
                w.cnt_m1 = 2'(m_cnt);
                w.lanes  = m_lanes;
                sb.push_back(w);
                m_lanes = '0;
                m_cnt   = 0;
            end else begin
                m_cnt++;
            end
        end
        @(negedge wr_clk);
        @(posedge wr_clk);
        #1;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic l,
                             input logic f);
        logic acc;
        int   tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 20) begin
            drive_cycle(1'b1, d, l, f, acc);
            tries++;
        end
        if (!acc) begin
            n_chk++;
            $display("FAIL send_timeout: beat %h not accepted in %0d cycles", d, tries);
        end
    endtask

    task automatic idle(input int n, input logic f);
        logic acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, '0, 1'b0, f, acc);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s_tvalid = 1'b1;
        s_tdata = 64'hDEAD;
        repeat (3) begin
            @(negedge wr_clk);
            n_chk++;
            if (wr_en !== 1'b0 || s_tready !== 1'b0)
                $display("FAIL reset_outs: wr_en=%b s_tready=%b want 0/0", wr_en, s_tready);
            else
                n_pass++;
        end
        n_chk++;
        if (wr_level !== 3'd0 || almost_full !== 1'b0)
            $display("FAIL reset_level: level=%0d af=%b want 0/0", wr_level, almost_full);
        else
            n_pass++;
        @(posedge wr_clk);
        #1;
        rst = 1'b0;
        s_tvalid = 1'b0;
        mon_en = 1'b1;
        idle(2, 1'b0);
    endtask

    task automatic test_back_to_back();
        int w0;
        w0 = n_wr;
        for (int i = 1; i <= 8; i++) send_beat(64'(i), i == 8, 1'b0);
        idle(2, 1'b0);
        n_chk++;
        if (n_wr - w0 !== 2)
            $display("FAIL b2b_writes: got %0d want 2", n_wr - w0);
        else
            n_pass++;
    endtask

    task automatic test_partial();
        int w0;
        w0 = n_wr;
        send_beat(64'hA, 1'b0, 1'b0);
        send_beat(64'hB, 1'b0, 1'b0);
        send_beat(64'hC, 1'b1, 1'b0);
        idle(2, 1'b0);
        send_beat(64'hE, 1'b1, 1'b0);
        idle(2, 1'b0);
        n_chk++;
        if (n_wr - w0 !== 2)
            $display("FAIL partial_writes: got %0d want 2", n_wr - w0);
        else
            n_pass++;
    endtask

    task automatic test_full();
        logic acc;
        for (int i = 0; i < 4; i++) send_beat(64'h100 + 64'(i), 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 64'h104, 1'b0, 1'b1, acc);
            n_chk++;
            if (acc !== 1'b0)
                $display("FAIL full_hold: beat accepted while full");
            else
                n_pass++;
        end
        for (int i = 4; i < 8; i++) send_beat(64'h100 + 64'(i), i == 7, 1'b0);
        idle(2, 1'b0);
    endtask

    task automatic test_reset_mid();
        int w0;
        w0 = n_wr;
        send_beat(64'h55, 1'b0, 1'b0);
        send_beat(64'h66, 1'b0, 1'b0);
        mon_en = 1'b0;
        rst = 1'b1;
        s_tvalid = 1'b1;
        s_tdata = 64'h77;
        repeat (2) begin
            @(negedge wr_clk);
            n_chk++;
            if (wr_en !== 1'b0 || s_tready !== 1'b0)
                $display("FAIL rst_mid: wr_en=%b s_tready=%b want 0/0", wr_en, s_tready);
            else
                n_pass++;
            @(posedge wr_clk);
            #1;
        end
        rst = 1'b0;
        s_tvalid = 1'b0;
        m_lanes = '0;
        m_cnt = 0;
        mon_en = 1'b1;
        idle(2, 1'b0);
        for (int i = 0; i < 4; i++) send_beat(64'h200 + 64'(i), 1'b0, 1'b0);
        idle(2, 1'b0);
        n_chk++;
        if (n_wr - w0 !== 1)
            $display("FAIL rst_mid_writes: got %0d want 1", n_wr - w0);
        else
            n_pass++;
    endtask

    task automatic test_level();
        logic [2:0] wb[4] = '{3'd5, 3'd1, 3'd3, 3'd6};
        logic [2:0] rb[4] = '{3'd1, 3'd7, 3'd0, 3'd4};
        logic [2:0] lv[4] = '{3'd4, 3'd2, 3'd3, 3'd2};
        logic       af[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        mon_en = 1'b0;
        wr_ptr = '0;
        rd_ptr_wsync = '0;
        @(posedge wr_clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            wr_ptr = b2g(wb[i]);
            rd_ptr_wsync = b2g(rb[i]);
            if (i == 0) begin
                @(negedge wr_clk);
                n_chk++;
                if (wr_level !== 3'd0)
                    $display("FAIL level_lag: got %0d want 0", wr_level);
                else
                    n_pass++;
            end
            @(posedge wr_clk);
            #1;
            n_chk++;
            if (wr_level !== lv[i] || almost_full !== af[i])
                $display("FAIL level_%0d: got %0d/%b want %0d/%b",
                         i, wr_level, almost_full, lv[i], af[i]);
            else
                n_pass++;
        end
        wr_ptr = '0;
        rd_ptr_wsync = '0;
        @(posedge wr_clk);
        #1;
        mon_en = 1'b1;
    endtask

    task automatic test_random();
        logic acc;
        logic [W-1:0] d;
        d = 64'h1000;
        for (int i = 0; i < 300; i++) begin
            drive_cycle($urandom_range(3) != 0, d, $urandom_range(4) == 0,
                        $urandom_range(2) == 0, acc);
            if (acc) d = d + 1;
        end
        idle(3, 1'b0);
        n_chk++;
        if (sb.size() != 0 || m_cnt != 0)
            $display("FAIL random_drain: %0d words left, %0d lanes open", sb.size(), m_cnt);
        else
            n_pass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_partial();
        test_full();
        test_reset_mid();
        test_level();
        test_random();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
